// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide responder.
// One tagged operation in flight, fixed 32-iteration latency.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef HART_ID_W
`define HART_ID_W 2
`endif
`ifndef REG_ADDR_W
`define REG_ADDR_W 5
`endif

module muldiv_unit #(
    parameter int XLEN       = `XLEN,
    parameter int HART_ID_W  = `HART_ID_W,
    parameter int REG_ADDR_W = `REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  muldiv_start,
    input  logic [2:0]            muldiv_op,
    input  logic [XLEN-1:0]       muldiv_a,
    input  logic [XLEN-1:0]       muldiv_b,
    input  logic [HART_ID_W-1:0]  muldiv_hart_id,
    input  logic [REG_ADDR_W-1:0] muldiv_rd,
    output logic                  muldiv_busy,
    output logic                  muldiv_done,
    output logic [XLEN-1:0]       muldiv_result,
    output logic [HART_ID_W-1:0]  muldiv_done_hart_id,
    output logic [REG_ADDR_W-1:0] muldiv_done_rd
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                state, state_n;
    logic                  accept, last;
    logic [CW-1:0]         cnt;
    logic [2:0]            op_q;
    logic [XLEN-1:0]       a_raw;
    logic [XLEN-1:0]       y, y_n;
    logic [2*XLEN-1:0]     acc, acc_n;
    logic [2*XLEN-1:0]     x, x_n;
    logic                  neg_p, neg_r;
    logic                  b_zero, ovf;
    logic [HART_ID_W-1:0]  hart_q;
    logic [REG_ADDR_W-1:0] rd_q;
    logic                  a_s, b_s;
    logic                  a_neg, b_neg;
    logic [XLEN-1:0]       a_mag, b_mag;
    logic [XLEN:0]         trial, diff;
    logic [2*XLEN-1:0]     prod;
    logic [XLEN-1:0]       quo, rem, res_n;

    assign accept      = (state == IDLE) && muldiv_start;
    assign last        = (state == RUN) && (cnt == LAST);
    assign muldiv_busy = (state != IDLE);
    assign muldiv_done = (state == DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (muldiv_start) state_n = RUN;
            RUN:     if (cnt == LAST) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        a_s   = (muldiv_op == 3'd1) || (muldiv_op == 3'd2) ||
                (muldiv_op == 3'd4) || (muldiv_op == 3'd6);
        b_s   = (muldiv_op == 3'd1) || (muldiv_op == 3'd4) ||
                (muldiv_op == 3'd6);
        a_neg = a_s && muldiv_a[XLEN-1];
        b_neg = b_s && muldiv_b[XLEN-1];
        a_mag = a_neg ? -muldiv_a : muldiv_a;
        b_mag = b_neg ? -muldiv_b : muldiv_b;
    end

    // Multiply: acc += x while x shifts left and y shifts right.
    // Divide: acc holds the partial remainder, y the dividend/quotient.
    always_comb begin
        acc_n = acc;
        x_n   = x;
        y_n   = y;
        trial = {acc[XLEN-1:0], y[XLEN-1]};
        diff  = trial - {1'b0, x[XLEN-1:0]};
        if (op_q[2]) begin
            if (!diff[XLEN]) begin
                acc_n = {{(XLEN-1){1'b0}}, diff};
                y_n   = {y[XLEN-2:0], 1'b1};
            end else begin
                acc_n = {{(XLEN-1){1'b0}}, trial};
                y_n   = {y[XLEN-2:0], 1'b0};
            end
        end else begin
            if (y[0]) acc_n = acc + x;
            x_n = x << 1;
            y_n = y >> 1;
        end
    end

    always_comb begin
        prod  = neg_p ? -acc_n : acc_n;
        quo   = neg_p ? -y_n : y_n;
        rem   = neg_r ? -acc_n[XLEN-1:0] : acc_n[XLEN-1:0];
        res_n = prod[XLEN-1:0];
        if (!op_q[2]) begin
            if (op_q[1:0] != 2'd0) res_n = prod[2*XLEN-1:XLEN];
        end else if (b_zero) begin
            res_n = op_q[1] ? a_raw : '1;
        end else if (ovf) begin
            res_n = op_q[1] ? '0 : MIN;
        end else begin
            res_n = op_q[1] ? rem : quo;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt    <= '0;
            op_q   <= '0;
            a_raw  <= '0;
            acc    <= '0;
            x      <= '0;
            y      <= '0;
            neg_p  <= 1'b0;
            neg_r  <= 1'b0;
            b_zero <= 1'b0;
            ovf    <= 1'b0;
            hart_q <= '0;
            rd_q   <= '0;
        end else if (accept) begin
            cnt    <= '0;
            op_q   <= muldiv_op;
            a_raw  <= muldiv_a;
            acc    <= '0;
            x      <= {{XLEN{1'b0}}, muldiv_op[2] ? b_mag : a_mag};
            y      <= muldiv_op[2] ? a_mag : b_mag;
            neg_p  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            b_zero <= (muldiv_b == '0);
            ovf    <= ((muldiv_op == 3'd4) || (muldiv_op == 3'd6)) &&
                      (muldiv_a == MIN) && (muldiv_b == '1);
            hart_q <= muldiv_hart_id;
            rd_q   <= muldiv_rd;
        end else if (state == RUN) begin
            cnt <= cnt + 1'b1;
            acc <= acc_n;
            x   <= x_n;
            y   <= y_n;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            muldiv_result       <= '0;
            muldiv_done_hart_id <= '0;
            muldiv_done_rd      <= '0;
        end else if (last) begin
            muldiv_result       <= res_n;
            muldiv_done_hart_id <= hart_q;
            muldiv_done_rd      <= rd_q;
        end
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide responder attached to the `cpu_top` muldiv port; it is the other end of the `muldiv_start`/`muldiv_done` interface driven by the CPU. It accepts one tagged operation at a time, computes it over a fixed 32-cycle iteration phase, and returns the result with the originating hart id and destination register so the CPU can write back to the correct hart's register file.

## Interface

Parameters:
- `XLEN`, default `` `XLEN `` (32): operand and result width.
- `HART_ID_W`, default `` `HART_ID_W ``: hart tag width.
- `REG_ADDR_W`, default `` `REG_ADDR_W `` (5): destination register tag width.

Ports (reset is synchronous, active-low; single clock):
- `clk`, in, 1: clock; all state updates on the rising edge.
- `rst_n`, in, 1: synchronous active-low reset.
- `muldiv_start`, in, 1: request strobe; sampled only when `muldiv_busy`=0.
- `muldiv_op`, in, 3: operation code, equal to RV32M funct3. 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `muldiv_a`, in, XLEN: rs1 operand (multiplicand/dividend).
- `muldiv_b`, in, XLEN: rs2 operand (multiplier/divisor).
- `muldiv_hart_id`, in, HART_ID_W: requesting hart tag.
- `muldiv_rd`, in, REG_ADDR_W: destination register tag.
- `muldiv_busy`, out, 1: an operation is in flight; new starts are ignored.
- `muldiv_done`, out, 1: one-cycle completion pulse.
- `muldiv_result`, out, XLEN: result, valid while `muldiv_done`=1.
- `muldiv_done_hart_id`, out, HART_ID_W: tag echoed with the result.
- `muldiv_done_rd`, out, REG_ADDR_W: rd echoed with the result.

## Operation

- FSM states:
  - IDLE: `busy`=0. On `start`, capture op, a, b, hart_id and rd, then go to RUN with iteration count 0.
  - RUN: `busy`=1. One iteration per cycle for 32 cycles; after iteration 31, go to DONE.
  - DONE: `busy`=1, `done`=1 for exactly one cycle, then return to IDLE.
- Operands and tags are registered at acceptance. Input changes after the accept edge have no effect.
- Sign handling: operands are converted to magnitudes according to op signedness.
  - MULH: both operands signed.
  - MULHSU: a signed, b unsigned.
  - MULHU, DIVU, REMU: both unsigned.
  - DIV, REM: both signed.
- Multiply:
  - Unsigned shift-add over 32 iterations into a 64-bit product.
  - Negate the product if the operand signs differ.
  - MUL returns bits [31:0]; MULH, MULHSU and MULHU return bits [63:32].
- Divide:
  - Restoring division over 32 iterations, one quotient bit per cycle.
  - The quotient is negated if the signs differ (signed ops only).
  - The remainder takes the sign of the dividend.
- Special cases (latency stays fixed at 32 iterations; the result is overridden in DONE):
  - Divisor 0: DIV/DIVU return 0xFFFFFFFF; REM/REMU return a.
  - Signed overflow (a=0x80000000, b=0xFFFFFFFF): DIV returns 0x80000000; REM returns 0.
- Output registers:
  - `result`, `done_hart_id` and `done_rd` are registered and hold their last value outside DONE.
  - Consumers qualify them with `done` only.
- `start` while `busy`=1, including during DONE, is dropped silently. There is no queueing and no error flag.

## Timing

- Reset values: `busy`=0, `done`=0, `result`=0, `done_hart_id`=0, `done_rd`=0, state IDLE.
- Accept edge E0 (`start`=1 with `busy`=0):
  - `busy`=1 from E0 onward.
  - `done`=1 in the cycle between E32 and E33.
  - `busy`=0 after E33.
  - Earliest next accept is E34.
- Back-to-back throughput: one operation per 34 cycles.
- `rst_n`=0 on any edge returns the unit to IDLE with all outputs at reset values. An in-flight operation is abandoned and no `done` is produced.
- `start` and `rst_n`=0 on the same edge: reset wins and nothing is accepted.

## Test plan

- MUL a=7, b=0xFFFFFFFD (hart 1, rd 5) -> `done` exactly 32 cycles after the accept edge; result 0xFFFFFFEB; `done_hart_id`=1; `done_rd`=5.
- High-product variants:
  - MULH 0x80000000 × 0x80000000 -> 0x40000000.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFF.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE.
- Signed division: DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100 / 7 -> 14; REMU -> 2.
- Edge cases:
  - DIVU 5 / 0 -> 0xFFFFFFFF; REM 5 / 0 -> 5.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0.
  - Latency is still 32 cycles in every case.
- Busy handling: issue MUL (hart 0, rd 3), then pulse `start` with DIV (hart 1, rd 7) during RUN and again during DONE -> exactly one `done`, carrying hart 0, rd 3 and the MUL result. A start at E34 is accepted.
- Reset during operation: accept DIV, drive `rst_n`=0 at iteration 10 for one cycle -> `busy`=0 and no `done` within 40 cycles. A fresh MUL 3×4 then returns 12.
